// File: rtl/trigger_prescaler.sv
// Final trigger former: per-class prescale of electron/muon/pion edges, fixed-width
// trigger pulse plus dead time, and raw/accepted/vetoed scalers on the local bus.
module trigger_prescaler #(
  parameter logic [7:0]  BASE_ADDR = 8'hD0,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned DEAD_TIME = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        electron,
  input  logic        muon,
  input  logic        pion,
  input  logic [7:0]  Address,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        trig_out,
  output logic [2:0]  trig_type,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DEAD  = 2'd2
  } state_t;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_LEN - 1);
  localparam logic [15:0] DEAD_LAST  = 16'(DEAD_TIME - 1);

  state_t      state, state_nxt;
  logic [15:0] tcnt, tcnt_nxt;
  logic [2:0]  type_q;

  logic [2:0]  lvl, lvl_q, edges;
  logic [15:0] prescale [3];
  logic [15:0] pc       [3];
  logic [31:0] raw_cnt  [3];
  logic [31:0] acc_cnt;
  logic [31:0] veto_cnt;
  logic        enable;

  logic [2:0]  accept, pc_adv;
  logic        veto;

  logic [7:0]  offset;
  logic        in_range, wr_hit, wr_ctrl, clear;
  logic [2:0]  wr_ps;
  logic        unused_data_bits;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign lvl   = {pion, muon, electron};
  assign edges = lvl & ~lvl_q;

  // Offset wraps for addresses below BASE_ADDR, so both bounds are needed
  assign offset   = Address - BASE_ADDR;
  assign in_range = (Address >= BASE_ADDR) && (offset <= 8'd8);
  assign wr_hit   = Write && in_range;
  assign wr_ctrl  = wr_hit && (offset == 8'd0);
  assign clear    = wr_ctrl && DataIn[1];
  assign wr_ps[0] = wr_hit && (offset == 8'd1);
  assign wr_ps[1] = wr_hit && (offset == 8'd2);
  assign wr_ps[2] = wr_hit && (offset == 8'd3);

  assign unused_data_bits = ^DataIn[31:16];

  always_ff @(posedge clk) begin
    if (!rst) lvl_q <= '0;
    else      lvl_q <= lvl;
  end

  // Prescale decisions only happen in IDLE with the block enabled; P=0 masks the class
  always_comb begin
    accept = '0;
    pc_adv = '0;
    for (int i = 0; i < 3; i++) begin
      if (state == IDLE && enable && edges[i] && prescale[i] != 16'd0) begin
        pc_adv[i] = 1'b1;
        if (pc[i] == prescale[i] - 16'd1) accept[i] = 1'b1;
      end
    end
  end

  assign veto = (|edges) && ((state != IDLE) || !enable);

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: begin
        if (|accept) begin
          state_nxt = PULSE;
          tcnt_nxt  = '0;
        end
      end
      PULSE: begin
        if (tcnt == PULSE_LAST) begin
          tcnt_nxt  = '0;
          state_nxt = (DEAD_TIME == 0) ? IDLE : DEAD;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      DEAD: begin
        if (tcnt == DEAD_LAST) begin
          tcnt_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      tcnt   <= '0;
      type_q <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (state == IDLE && (|accept)) type_q <= accept;
    end
  end

  // Clear beats any same-cycle increment; a prescale write restarts that class's count
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        prescale[i] <= 16'd1;
        pc[i]       <= '0;
        raw_cnt[i]  <= '0;
      end
      acc_cnt  <= '0;
      veto_cnt <= '0;
      enable   <= 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clear) begin
          raw_cnt[i] <= '0;
          pc[i]      <= '0;
        end else begin
          if (edges[i]) raw_cnt[i] <= sat_inc(raw_cnt[i]);
          if (wr_ps[i])       pc[i] <= '0;
          else if (pc_adv[i]) pc[i] <= accept[i] ? 16'd0 : pc[i] + 16'd1;
        end
        if (wr_ps[i]) prescale[i] <= DataIn[15:0];
      end
      if (clear) begin
        acc_cnt  <= '0;
        veto_cnt <= '0;
      end else begin
        if (|accept) acc_cnt  <= sat_inc(acc_cnt);
        if (veto)    veto_cnt <= sat_inc(veto_cnt);
      end
      if (wr_ctrl) enable <= DataIn[0];
    end
  end

  always_comb begin
    DataOut = '0;
    if (Read && in_range) begin
      case (offset)
        8'd0:    DataOut = {31'd0, enable};
        8'd1:    DataOut = {16'd0, prescale[0]};
        8'd2:    DataOut = {16'd0, prescale[1]};
        8'd3:    DataOut = {16'd0, prescale[2]};
        8'd4:    DataOut = raw_cnt[0];
        8'd5:    DataOut = raw_cnt[1];
        8'd6:    DataOut = raw_cnt[2];
        8'd7:    DataOut = acc_cnt;
        8'd8:    DataOut = veto_cnt;
        default: DataOut = '0;
      endcase
    end
  end

  assign trig_out  = (state == PULSE);
  assign trig_type = trig_out ? type_q : 3'b000;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_trigger_prescaler.sv
// Bench for trigger_prescaler: reset register table, directed corner sequences and
// random traffic, all checked against a countdown/array model of the trigger rules.
module tb_trigger_prescaler;

  localparam logic [7:0] BASE = 8'hD0;
  localparam int PL = 4;
  localparam int DT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        electron = 1'b0, muon = 1'b0, pion = 1'b0;
  logic [7:0]  Address = '0;
  logic        Read = 1'b0, Write = 1'b0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        trig_out;
  logic [2:0]  trig_type;
  logic        busy;

  trigger_prescaler #(.BASE_ADDR(BASE), .PULSE_LEN(PL), .DEAD_TIME(DT)) dut (
    .clk(clk), .rst(rst), .electron(electron), .muon(muon), .pion(pion),
    .Address(Address), .Read(Read), .Write(Write), .DataIn(DataIn),
    .DataOut(DataOut), .trig_out(trig_out), .trig_type(trig_type), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: busy_left counts remaining busy cycles; the first PL of them are the pulse
  logic [2:0]  m_prev;
  int          m_ps [3];
  int          m_pc [3];
  logic [31:0] m_raw [3];
  logic [31:0] m_acc, m_veto;
  logic        m_en;
  int          m_busy_left;
  logic [2:0]  m_type;

  int          hi_cycles, busy_cycles, n_trig;
  logic        last_trig;
  logic [31:0] rd_val;

  typedef struct {
    int          off;
    logic [31:0] exp;
  } reg_vec_t;
  reg_vec_t rst_tab [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] modelReg(input int off);
    case (off)
      0:       return {31'd0, m_en};
      1, 2, 3: return 32'(m_ps[off-1]);
      4, 5, 6: return m_raw[off-4];
      7:       return m_acc;
      8:       return m_veto;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    m_prev = '0;
    for (int i = 0; i < 3; i++) begin
      m_ps[i] = 1; m_pc[i] = 0; m_raw[i] = '0;
    end
    m_acc = '0; m_veto = '0; m_en = 1'b1; m_busy_left = 0; m_type = '0;
  endtask

  task automatic modelStep(input logic [2:0] lv, input logic wr, input int woff, input logic [31:0] wd);
    logic [2:0] e;
    logic [2:0] acc;
    e = lv & ~m_prev;
    m_prev = lv;
    acc = '0;
    for (int i = 0; i < 3; i++) if (e[i]) m_raw[i] = sat(m_raw[i]);
    if (m_busy_left > 0) begin
      if (|e) m_veto = sat(m_veto);
      m_busy_left--;
    end else if (!m_en) begin
      if (|e) m_veto = sat(m_veto);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (e[i] && m_ps[i] != 0) begin
          if (m_pc[i] == m_ps[i] - 1) begin acc[i] = 1'b1; m_pc[i] = 0; end
          else m_pc[i]++;
        end
      end
      if (|acc) begin
        m_acc = sat(m_acc); m_type = acc; m_busy_left = PL + DT;
      end
    end
    if (wr && woff == 0) begin
      m_en = wd[0];
      if (wd[1]) begin
        for (int i = 0; i < 3; i++) begin m_raw[i] = '0; m_pc[i] = 0; end
        m_acc = '0; m_veto = '0;
      end
    end else if (wr && woff >= 1 && woff <= 3) begin
      m_ps[woff-1] = int'(wd[15:0]);
      m_pc[woff-1] = 0;
    end
  endtask

  // One clock cycle: drive at negedge, optional bus read, then compare outputs after posedge
  task automatic applyStimulus(input logic [2:0] lv, input logic wr = 1'b0, input int woff = 0,
                               input logic [31:0] wd = '0, input logic rd = 1'b0, input int roff = 0);
    logic m_trig;
    @(negedge clk);
    rst = 1'b1;
    {pion, muon, electron} = lv;
    Write   = wr;
    Read    = rd;
    DataIn  = wd;
    Address = BASE + 8'(wr ? woff : roff);
    #1;
    rd_val = DataOut;
    checkOutput($sformatf("DataOut rd=%0d off=%0d", rd, roff), DataOut, rd ? modelReg(roff) : 32'd0);
    @(posedge clk);
    modelStep(lv, wr, woff, wd);
    #1;
    m_trig = (m_busy_left > DT);
    checkOutput("trig_out", {31'd0, trig_out}, {31'd0, m_trig});
    checkOutput("busy", {31'd0, busy}, {31'd0, m_busy_left > 0});
    checkOutput("trig_type", {29'd0, trig_type}, {29'd0, m_trig ? m_type : 3'b000});
    if (trig_out) hi_cycles++;
    if (busy) busy_cycles++;
    if (trig_out && !last_trig) n_trig++;
    last_trig = trig_out;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(3'b000);
  endtask

  task automatic readConst(input string name, input int off, input logic [31:0] exp);
    applyStimulus(3'b000, 1'b0, 0, '0, 1'b1, off);
    checkOutput(name, rd_val, exp);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    {pion, muon, electron} = 3'b000;
    Write = 1'b0; Read = 1'b0;
    @(posedge clk);
    modelReset();
    last_trig = 1'b0;
    #1;
    checkOutput("reset trig_out", {31'd0, trig_out}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset trig_type", {29'd0, trig_type}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_tab[0] = '{0, 32'h1};
    rst_tab[1] = '{1, 32'h1};
    rst_tab[2] = '{2, 32'h1};
    rst_tab[3] = '{3, 32'h1};
    rst_tab[4] = '{4, 32'h0};
    rst_tab[5] = '{5, 32'h0};
    rst_tab[6] = '{6, 32'h0};
    rst_tab[7] = '{7, 32'h0};
    rst_tab[8] = '{8, 32'h0};
    rst_tab[9] = '{9, 32'h0};

    doReset();
    doReset();
    for (int i = 0; i < 10; i++)
      readConst($sformatf("reset reg off %0d", rst_tab[i].off), rst_tab[i].off, rst_tab[i].exp);

    // Single electron
    hi_cycles = 0; busy_cycles = 0; n_trig = 0;
    applyStimulus(3'b001);
    checkOutput("single trig_type", {29'd0, trig_type}, 32'd1);
    applyStimulus(3'b001);
    idle(30);
    checkOutput("single pulse width", 32'(hi_cycles), 32'd4);
    checkOutput("single busy width", 32'(busy_cycles), 32'd20);
    readConst("single raw_e", 4, 32'd1);
    readConst("single accepted", 7, 32'd1);

    // Muon prescale 3
    doReset();
    applyStimulus(3'b000, 1'b1, 2, 32'd3);
    n_trig = 0;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(3'b010);
      checkOutput($sformatf("muon triggers after edge %0d", k), 32'(n_trig), 32'(k / 3));
      idle(29);
    end
    readConst("muon raw", 5, 32'd9);
    readConst("muon accepted", 7, 32'd3);
    readConst("muon vetoed", 8, 32'd0);

    // Coincident electron+pion, then muon in dead window
    doReset();
    n_trig = 0;
    applyStimulus(3'b101);
    checkOutput("coinc trig_type", {29'd0, trig_type}, 32'd5);
    idle(4);
    applyStimulus(3'b010);
    idle(25);
    checkOutput("coinc trigger count", 32'(n_trig), 32'd1);
    readConst("coinc accepted", 7, 32'd1);
    readConst("coinc vetoed", 8, 32'd1);
    readConst("coinc raw_mu", 5, 32'd1);

    // Pion disabled by P=0, then block disabled
    doReset();
    n_trig = 0;
    applyStimulus(3'b000, 1'b1, 3, 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b100);
      applyStimulus(3'b000);
    end
    idle(3);
    checkOutput("pion P=0 triggers", 32'(n_trig), 32'd0);
    readConst("pion P=0 raw", 6, 32'd4);
    readConst("pion P=0 vetoed", 8, 32'd0);
    applyStimulus(3'b000, 1'b1, 0, 32'd0);
    applyStimulus(3'b001);
    idle(3);
    checkOutput("disabled triggers", 32'(n_trig), 32'd0);
    readConst("disabled vetoed", 8, 32'd1);

    // Accepted saturation, clear on edge, reset mid-pulse
    doReset();
    force dut.acc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.acc_cnt;
    m_acc = 32'hFFFF_FFFF;
    applyStimulus(3'b001);
    idle(25);
    readConst("accepted saturates", 7, 32'hFFFF_FFFF);
    applyStimulus(3'b010, 1'b1, 0, 32'h3);
    for (int off = 4; off <= 8; off++) readConst($sformatf("cleared off %0d", off), off, 32'd0);
    readConst("enable after clear", 0, 32'd1);
    idle(25);
    applyStimulus(3'b100);
    applyStimulus(3'b000);
    checkOutput("mid-pulse trig_out", {31'd0, trig_out}, 32'd1);
    doReset();

    // Random traffic against the model
    doReset();
    for (int i = 1; i <= 3; i++) applyStimulus(3'b000, 1'b1, i, 32'($urandom_range(0, 4)));
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] lv;
      int sel;
      for (int b = 0; b < 3; b++) lv[b] = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 199);
      if (sel < 2)
        applyStimulus(lv, 1'b1, 0, {30'd0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0)});
      else if (sel < 4)
        applyStimulus(lv, 1'b1, $urandom_range(1, 3), $urandom());
      else if (sel < 5)
        applyStimulus(lv, 1'b1, $urandom_range(4, 9), $urandom());
      else if (sel < 30)
        applyStimulus(lv, 1'b0, 0, '0, 1'b1, $urandom_range(0, 9));
      else
        applyStimulus(lv);
    end
    idle(25);
    for (int off = 0; off <= 8; off++) applyStimulus(3'b000, 1'b0, 0, '0, 1'b1, off);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
